risc_host_sequencer: RTL and testbench

//  Host-side controller for the my_risc core and its 128x16 unified memory. It loads program and data

---
 rtl/risc_host_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_risc_host_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_host_sequencer.sv
// Host-side sequencer for the my_risc core: loads memory over the external access port, starts
// the core, waits for done (or timeout), then streams a result window back out.
module risc_host_sequencer #(
    parameter int unsigned AW      = 7,
    parameter int unsigned DW      = 16,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          Iclk,
    input  logic          Ireset,
    input  logic          Iload_valid,
    output logic          Oload_ready,
    input  logic [AW-1:0] Iload_addr,
    input  logic [DW-1:0] Iload_data,
    input  logic          Iload_last,
    input  logic [AW-1:0] Idump_base,
    input  logic [AW:0]   Idump_len,
    output logic          Odump_valid,
    output logic [AW-1:0] Odump_addr,
    output logic [DW-1:0] Odump_data,
    output logic          Ocore_access,
    output logic          Ocore_wrb,
    output logic [AW-1:0] Ocore_addr,
    output logic [DW-1:0] Ocore_wdata,
    input  logic [DW-1:0] Icore_rdata,
    output logic          Ocore_start,
    input  logic          Icore_done,
    output logic          Obusy,
    output logic          Odone,
    output logic          Otimeout,
    output logic [CNT_W-1:0] Orun_cycles
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StDump,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic             access_q, access_d;
    logic             wrb_q, wrb_d;
    logic             start_q, start_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             issue_q, issue_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      tmr_q, tmr_d;
    logic [AW-1:0]    base_q, base_d;
    logic [AW:0]      len_q, len_d;
    logic [AW:0]      iss_q, iss_d;
    logic [AW:0]      rcv_q, rcv_d;

    logic             dump_valid;
    logic [AW-1:0]    dump_addr;

    // Issue stage is the registered core address itself; extra stages track read latency.
    if (RD_LAT == 0) begin : g_lat0
        assign dump_valid = issue_q;
        assign dump_addr  = addr_q;
    end else begin : g_lat
        logic [RD_LAT-1:0] vld_q;
        logic [AW-1:0]     adr_q [RD_LAT];

        always_ff @(posedge Iclk) begin
            if (Ireset) begin
                vld_q <= '0;
                for (int i = 0; i < int'(RD_LAT); i++) begin
                    adr_q[i] <= '0;
                end
            end else begin
                vld_q[0] <= issue_q;
                adr_q[0] <= addr_q;
                for (int i = 1; i < int'(RD_LAT); i++) begin
                    vld_q[i] <= vld_q[i-1];
                    adr_q[i] <= adr_q[i-1];
                end
            end
        end

        assign dump_valid = vld_q[RD_LAT-1];
        assign dump_addr  = adr_q[RD_LAT-1];
    end

    always_comb begin
        state_d  = state_q;
        access_d = access_q;
        wrb_d    = wrb_q;
        start_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        issue_d  = 1'b0;
        done_d   = done_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        base_d   = base_q;
        len_d    = len_q;
        iss_d    = iss_q;
        rcv_d    = rcv_q;
        unique case (state_q)
            StIdle, StLoad, StDone, StErr: begin
                access_d = 1'b1;
                wrb_d    = 1'b1;
                if (Iload_valid) begin
                    wrb_d   = 1'b0;
                    addr_d  = Iload_addr;
                    wdata_d = Iload_data;
                    state_d = StLoad;
                    if (state_q != StLoad) begin
                        done_d = 1'b0;
                        tmo_d  = 1'b0;
                        cnt_d  = '0;
                    end
                    if (Iload_last) begin
                        base_d  = Idump_base;
                        len_d   = Idump_len;
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                access_d = 1'b0;
                wrb_d    = 1'b1;
                start_d  = 1'b1;
                tmr_d    = '0;
                state_d  = StRun;
            end
            StRun: begin
                access_d = 1'b0;
                wrb_d    = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                tmr_d = tmr_q + 32'd1;
                // Done is checked first so it wins over a coincident timeout.
                if (Icore_done) begin
                    access_d = 1'b1;
                    if (len_q == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StDump;
                        issue_d = 1'b1;
                        addr_d  = base_q;
                        iss_d   = len_q - 1'b1;
                        rcv_d   = len_q;
                    end
                end else if (TIMEOUT != 0 && tmr_q + 32'd1 == TIMEOUT) begin
                    state_d  = StErr;
                    access_d = 1'b1;
                    tmo_d    = 1'b1;
                end
            end
            StDump: begin
                access_d = 1'b1;
                wrb_d    = 1'b1;
                if (iss_q != '0) begin
                    issue_d = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    iss_d   = iss_q - 1'b1;
                end
                if (dump_valid) begin
                    rcv_d = rcv_q - 1'b1;
                    if (rcv_q == {{AW{1'b0}}, 1'b1}) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Iclk) begin
        if (Ireset) begin
            state_q  <= StIdle;
            access_q <= 1'b1;
            wrb_q    <= 1'b1;
            start_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            issue_q  <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            base_q   <= '0;
            len_q    <= '0;
            iss_q    <= '0;
            rcv_q    <= '0;
        end else begin
            state_q  <= state_d;
            access_q <= access_d;
            wrb_q    <= wrb_d;
            start_q  <= start_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            issue_q  <= issue_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            base_q   <= base_d;
            len_q    <= len_d;
            iss_q    <= iss_d;
            rcv_q    <= rcv_d;
        end
    end

    assign Oload_ready  = (state_q == StIdle) || (state_q == StLoad) ||
                          (state_q == StDone) || (state_q == StErr);
    assign Obusy        = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
    assign Odump_valid  = dump_valid;
    assign Odump_addr   = dump_valid ? dump_addr : '0;
    assign Odump_data   = dump_valid ? Icore_rdata : '0;
    assign Ocore_access = access_q;
    assign Ocore_wrb    = wrb_q;
    assign Ocore_addr   = addr_q;
    assign Ocore_wdata  = wdata_q;
    assign Ocore_start  = start_q;
    assign Odone        = done_q;
    assign Otimeout     = tmo_q;
    assign Orun_cycles  = cnt_q;

endmodule

// File: tb/tb_risc_host_sequencer.sv
// Three sequencers (read latency 0, 1, 3) driven in lockstep; per-instance memory and core model,
// scoreboards for memory writes and dump words.
module tb_risc_host_sequencer;

    localparam int NI  = 3;
    localparam int TMO = 20;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 3;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid, load_last, core_done;
    logic [6:0]  load_addr, dump_base;
    logic [15:0] load_data;
    logic [7:0]  dump_len;

    logic        o_ready [NI], o_dvalid [NI], o_acc [NI], o_wrb [NI], o_start [NI];
    logic        o_busy [NI], o_done [NI], o_tmo [NI];
    logic [6:0]  o_daddr [NI], o_caddr [NI];
    logic [15:0] o_ddata [NI], o_wdata [NI], rdata [NI], o_cyc [NI];

    logic [15:0] mem [NI][128] = '{default: '0};
    logic [15:0] ref_mem [128] = '{default: '0};
    logic [6:0]  ap [NI][3];
    logic        done_seen = 1'b0;

    logic [22:0] wq [NI][$];
    logic [22:0] dq [NI][$];
    int          wcnt [NI];
    int          scnt [NI];
    logic [6:0]  ba [$];
    logic [15:0] bd [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    risc_host_sequencer #(.RD_LAT(0), .TIMEOUT(TMO)) u_dut0 (
        .Iclk(clk), .Ireset(rst), .Iload_valid(load_valid), .Oload_ready(o_ready[0]),
        .Iload_addr(load_addr), .Iload_data(load_data), .Iload_last(load_last),
        .Idump_base(dump_base), .Idump_len(dump_len), .Odump_valid(o_dvalid[0]),
        .Odump_addr(o_daddr[0]), .Odump_data(o_ddata[0]), .Ocore_access(o_acc[0]),
        .Ocore_wrb(o_wrb[0]), .Ocore_addr(o_caddr[0]), .Ocore_wdata(o_wdata[0]),
        .Icore_rdata(rdata[0]), .Ocore_start(o_start[0]), .Icore_done(core_done),
        .Obusy(o_busy[0]), .Odone(o_done[0]), .Otimeout(o_tmo[0]), .Orun_cycles(o_cyc[0]));

    risc_host_sequencer #(.RD_LAT(1), .TIMEOUT(TMO)) u_dut1 (
        .Iclk(clk), .Ireset(rst), .Iload_valid(load_valid), .Oload_ready(o_ready[1]),
        .Iload_addr(load_addr), .Iload_data(load_data), .Iload_last(load_last),
        .Idump_base(dump_base), .Idump_len(dump_len), .Odump_valid(o_dvalid[1]),
        .Odump_addr(o_daddr[1]), .Odump_data(o_ddata[1]), .Ocore_access(o_acc[1]),
        .Ocore_wrb(o_wrb[1]), .Ocore_addr(o_caddr[1]), .Ocore_wdata(o_wdata[1]),
        .Icore_rdata(rdata[1]), .Ocore_start(o_start[1]), .Icore_done(core_done),
        .Obusy(o_busy[1]), .Odone(o_done[1]), .Otimeout(o_tmo[1]), .Orun_cycles(o_cyc[1]));

    risc_host_sequencer #(.RD_LAT(3), .TIMEOUT(TMO)) u_dut2 (
        .Iclk(clk), .Ireset(rst), .Iload_valid(load_valid), .Oload_ready(o_ready[2]),
        .Iload_addr(load_addr), .Iload_data(load_data), .Iload_last(load_last),
        .Idump_base(dump_base), .Idump_len(dump_len), .Odump_valid(o_dvalid[2]),
        .Odump_addr(o_daddr[2]), .Odump_data(o_ddata[2]), .Ocore_access(o_acc[2]),
        .Ocore_wrb(o_wrb[2]), .Ocore_addr(o_caddr[2]), .Ocore_wdata(o_wdata[2]),
        .Icore_rdata(rdata[2]), .Ocore_start(o_start[2]), .Icore_done(core_done),
        .Obusy(o_busy[2]), .Odone(o_done[2]), .Otimeout(o_tmo[2]), .Orun_cycles(o_cyc[2]));

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [inst %0d]: got %0d, expected %0d", name, inst, act, exp);
        end
    endtask

    // Core memory: writes land at the end of the write cycle; the "divide program" runs at done.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (o_acc[i] && !o_wrb[i]) mem[i][o_caddr[i]] <= o_wdata[i];
            if (core_done && !done_seen && mem[i][64] != 16'd0)
                mem[i][66] <= mem[i][65] / mem[i][64];
            ap[i][0] <= o_caddr[i];
            ap[i][1] <= ap[i][0];
            ap[i][2] <= ap[i][1];
        end
        done_seen <= core_done;
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            rdata[i] = '0;
            if (lat_of(i) == 0) rdata[i] = mem[i][o_caddr[i]];
            else rdata[i] = mem[i][ap[i][lat_of(i)-1]];
        end
    end

    // Monitor: pops the scoreboards whenever a DUT presents a write or a dump word.
    always @(negedge clk) begin
        logic [22:0] e;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                wq[i].delete();
                dq[i].delete();
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (o_start[i]) scnt[i]++;
                if (o_acc[i] && !o_wrb[i]) begin
                    wcnt[i]++;
                    chk("write_expected", i, wq[i].size() != 0, 1);
                    if (wq[i].size() != 0) begin
                        e = wq[i].pop_front();
                        chk("write_addr", i, o_caddr[i], e[22:16]);
                        chk("write_data", i, o_wdata[i], e[15:0]);
                    end
                end
                if (o_dvalid[i]) begin
                    chk("dump_expected", i, dq[i].size() != 0, 1);
                    if (dq[i].size() != 0) begin
                        e = dq[i].pop_front();
                        chk("dump_addr", i, o_daddr[i], e[22:16]);
                        chk("dump_data", i, o_ddata[i], e[15:0]);
                    end
                end
            end
        end
    end

    function automatic bit any_busy();
        return o_busy[0] || o_busy[1] || o_busy[2];
    endfunction

    task automatic check_reset();
        for (int i = 0; i < NI; i++) begin
            chk("rst_access", i, o_acc[i], 1);
            chk("rst_wrb", i, o_wrb[i], 1);
            chk("rst_start", i, o_start[i], 0);
            chk("rst_core_addr", i, o_caddr[i], 0);
            chk("rst_wdata", i, o_wdata[i], 0);
            chk("rst_ready", i, o_ready[i], 1);
            chk("rst_dump_valid", i, o_dvalid[i], 0);
            chk("rst_dump_addr", i, o_daddr[i], 0);
            chk("rst_dump_data", i, o_ddata[i], 0);
            chk("rst_busy", i, o_busy[i], 0);
            chk("rst_done", i, o_done[i], 0);
            chk("rst_timeout", i, o_tmo[i], 0);
            chk("rst_cycles", i, o_cyc[i], 0);
        end
    endtask

    task automatic load_beats(input logic [6:0] base, input logic [7:0] len);
        int n;
        n = ba.size();
        for (int i = 0; i < NI; i++) begin
            wcnt[i] = 0;
            scnt[i] = 0;
        end
        for (int b = 0; b < n; b++) begin
            load_valid = 1'b1;
            load_addr  = ba[b];
            load_data  = bd[b];
            load_last  = (b == n - 1);
            dump_base  = base;
            dump_len   = len;
            for (int i = 0; i < NI; i++) wq[i].push_back({ba[b], bd[b]});
            ref_mem[ba[b]] = bd[b];
            @(negedge clk);
            load_valid = 1'b0;
            load_last  = 1'b0;
            dump_base  = 7'($urandom);
            dump_len   = 8'($urandom);
            if (b == 0 && n > 1) begin
                for (int i = 0; i < NI; i++) begin
                    chk("first_beat_done_clr", i, o_done[i], 0);
                    chk("first_beat_tmo_clr", i, o_tmo[i], 0);
                    chk("first_beat_cyc_clr", i, o_cyc[i], 0);
                end
            end
            if (b != n - 1 && $urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while (!o_start[0] && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", 0, o_start[0], 1);
        core_done = 1'b0;
        for (int i = 0; i < NI; i++) chk("ready_low_in_run", i, o_ready[i], 0);
    endtask

    task automatic raise_done(input logic [6:0] base, input logic [7:0] len);
        logic [6:0] a;
        core_done = 1'b1;
        if (ref_mem[64] != 16'd0) ref_mem[66] = ref_mem[65] / ref_mem[64];
        for (int j = 0; j < int'(len); j++) begin
            a = 7'(int'(base) + j);
            for (int i = 0; i < NI; i++) dq[i].push_back({a, ref_mem[a]});
        end
    endtask

    // Full run: load the beats in ba/bd, let the core run k extra cycles (or never finish).
    task automatic run(input logic [6:0] base, input logic [7:0] len, input int k,
                       input bit tmo);
        int t;
        int exp_cyc;
        int n;
        n = ba.size();
        load_beats(base, len);
        wait_start();
        if (!tmo) begin
            repeat (k) @(negedge clk);
            raise_done(base, len);
            exp_cyc = k + 1;
        end else begin
            exp_cyc = TMO;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (any_busy() && t < 400);
        chk("run_finished", 0, any_busy(), 0);
        for (int i = 0; i < NI; i++) begin
            chk("done_flag", i, o_done[i], tmo ? 0 : 1);
            chk("timeout_flag", i, o_tmo[i], tmo ? 1 : 0);
            chk("run_cycles", i, o_cyc[i], exp_cyc);
            chk("dump_words_left", i, dq[i].size(), 0);
            chk("start_pulses", i, scnt[i], 1);
            chk("write_cycles", i, wcnt[i], n);
            chk("ready_after_run", i, o_ready[i], 1);
        end
    endtask

    task automatic pulse_reset();
        rst       = 1'b1;
        core_done = 1'b0;
        @(negedge clk);
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        dump_base  = '0;
        dump_len   = '0;
        core_done  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);
        check_reset();

        // Divide program plus operands, result window 64..66.
        ba.delete(); bd.delete();
        for (int a = 0; a < 26; a++) begin
            ba.push_back(7'(a));
            bd.push_back(16'($urandom));
        end
        ba.push_back(7'd64); bd.push_back(16'd3);
        ba.push_back(7'd65); bd.push_back(16'd12);
        run(7'd64, 8'd3, $urandom_range(2, 12), 1'b0);

        // Core never finishes; single beat that is also the last.
        ba.delete(); bd.delete();
        ba.push_back(7'd10); bd.push_back(16'h1234);
        run(7'd0, 8'd5, 0, 1'b1);

        // Window wrapping past the top of memory.
        ba.delete(); bd.delete();
        ba.push_back(7'd126); bd.push_back(16'hA5A5);
        ba.push_back(7'd1);   bd.push_back(16'h5A5A);
        run(7'd126, 8'd4, 3, 1'b0);

        // Done on the very cycle the timeout would fire.
        ba.delete(); bd.delete();
        ba.push_back(7'd20); bd.push_back(16'hBEEF);
        run(7'd20, 8'd2, TMO - 1, 1'b0);

        // Empty window, then a multi-beat load that must clear the sticky flags.
        ba.delete(); bd.delete();
        ba.push_back(7'd30); bd.push_back(16'h0042);
        run(7'd30, 8'd0, 5, 1'b0);
        ba.delete(); bd.delete();
        for (int a = 0; a < 3; a++) begin
            ba.push_back(7'(40 + a));
            bd.push_back(16'($urandom));
        end
        run(7'd40, 8'd3, 1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            int nb;
            nb = $urandom_range(1, 6);
            ba.delete(); bd.delete();
            for (int b = 0; b < nb; b++) begin
                ba.push_back(7'($urandom));
                bd.push_back(16'($urandom));
            end
            run(7'($urandom), 8'($urandom_range(0, 12)), $urandom_range(0, TMO - 2),
                $urandom_range(0, 4) == 0);
        end

        // Reset while running.
        ba.delete(); bd.delete();
        ba.push_back(7'd50); bd.push_back(16'h0777);
        ba.push_back(7'd51); bd.push_back(16'h0888);
        load_beats(7'd50, 8'd2);
        wait_start();
        repeat (3) @(negedge clk);
        pulse_reset();

        // Reset in the middle of a long dump.
        ba.delete(); bd.delete();
        ba.push_back(7'd5); bd.push_back(16'h0999);
        load_beats(7'd0, 8'd40);
        wait_start();
        repeat (2) @(negedge clk);
        raise_done(7'd0, 8'd40);
        repeat (6) @(negedge clk);
        for (int i = 0; i < NI; i++) chk("busy_in_dump", i, o_busy[i], 1);
        pulse_reset();

        // Recovery after reset, memory contents kept.
        ba.delete(); bd.delete();
        ba.push_back(7'd122); bd.push_back(16'h1357);
        run(7'd120, 8'd10, 4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
